// File: rtl/fb_row_prefetch_pkg.sv
// fb_row_prefetch shared constants.
// Holds the FSM encoding and panel geometry used across the LED path.
package fb_row_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam int PANEL_LINE_LEN = 416;
  localparam int PANEL_ROWS     = 8;

endpackage

// File: rtl/fb_row_prefetch_if.sv
// Framebuffer read bus between the row prefetcher and the framebuffer.
// The address is registered; read data follows one cycle later.
interface fb_row_prefetch_if #(
  parameter int FB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH    = 8
);

  logic [FB_ADDR_WIDTH-1:0] fb_addr;
  logic [DATA_WIDTH-1:0]    fb_data;

  modport master (
    output fb_addr,
    input  fb_data
  );

  modport slave (
    input  fb_addr,
    output fb_data
  );

endinterface

// File: rtl/fb_row_prefetch_line_ram_2bank.sv
// Two-bank line buffer: simple dual-port RAM with a registered read port.
// Bank 1 starts at DEPTH so both banks pack into one EBR-sized array.
module line_ram_2bank #(
  parameter int DEPTH      = 416,
  parameter int IDX_WIDTH  = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  wbank,
  input  logic [IDX_WIDTH-1:0]  widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rbank,
  input  logic [IDX_WIDTH-1:0]  ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int AW = IDX_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;

  function automatic logic [AW-1:0] map(
    input logic                 bank,
    input logic [IDX_WIDTH-1:0] idx
  );
    return (bank ? AW'(DEPTH) : AW'(0)) + AW'(idx);
  endfunction

  assign waddr = map(wbank, widx);
  assign raddr = map(rbank, ridx);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_row_prefetch.sv
// Scan-line prefetcher: fills one line bank from the framebuffer while the
// other bank serves single bit-planes to the panel shifter.
module fb_row_prefetch
  import fb_row_prefetch_pkg::*;
#(
  parameter int LINE_LEN       = PANEL_LINE_LEN,
  parameter int IDX_WIDTH      = 9,
  parameter int FB_ADDR_WIDTH  = 12,
  parameter int ROW_ADDR_WIDTH = 3,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      row_req,
  input  logic [ROW_ADDR_WIDTH-1:0] row_sel,
  fb_row_prefetch_if.master         fb,
  output logic                      row_ready,
  output logic                      busy,
  input  logic                      swap,
  input  logic [IDX_WIDTH-1:0]      rd_index,
  input  logic [2:0]                plane,
  output logic                      rd_bit,
  output logic                      overrun
);

  localparam int AW = FB_ADDR_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(LINE_LEN - 1);

  state_t                state;
  state_t                state_n;
  logic [AW-1:0]         base;
  logic [AW-1:0]         addr;
  logic [AW-1:0]         row_base;
  logic [IDX_WIDTH-1:0]  count;
  logic                  disp;
  logic                  v1;
  logic                  v2;
  logic [IDX_WIDTH-1:0]  i1;
  logic [IDX_WIDTH-1:0]  i2;
  logic                  accept;
  logic                  issue;
  logic                  flip;
  logic                  reject;
  logic                  last_wr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [2:0]            plane_q;

  assign row_base = AW'(row_sel) * AW'(LINE_LEN);
  assign last_wr  = v2 && (i2 == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    issue   = 1'b0;
    flip    = 1'b0;
    reject  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = row_req;
        reject = swap;
        if (row_req) state_n = FETCH;
      end
      FETCH: begin
        issue  = 1'b1;
        reject = row_req | swap;
        if (count == LAST) state_n = DRAIN;
      end
      DRAIN: begin
        reject = row_req | swap;
        if (last_wr) state_n = DONE;
      end
      DONE: begin
        // Refilling without a swap would clobber the row awaiting display.
        reject = row_req & ~swap;
        if (swap) begin
          flip    = 1'b1;
          accept  = row_req;
          state_n = row_req ? FETCH : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base      <= '0;
      addr      <= '0;
      count     <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      i1        <= '0;
      i2        <= '0;
      disp      <= 1'b0;
      busy      <= 1'b0;
      row_ready <= 1'b0;
      overrun   <= 1'b0;
      plane_q   <= '0;
    end else begin
      if (accept) begin
        base  <= row_base;
        addr  <= row_base;
        count <= IDX_WIDTH'(1);
      end else if (issue) begin
        addr  <= base + AW'(count);
        count <= count + IDX_WIDTH'(1);
      end
      // Write pipe matches the address register plus framebuffer latency.
      v1 <= accept | issue;
      i1 <= accept ? '0 : count;
      v2 <= v1;
      i2 <= i1;
      if (flip) disp <= ~disp;
      if (accept) begin
        busy <= 1'b1;
      end else if (state == DRAIN && last_wr) begin
        busy      <= 1'b0;
        row_ready <= 1'b1;
      end
      if (flip) row_ready <= 1'b0;
      overrun <= reject;
      plane_q <= plane;
    end
  end

  assign fb.fb_addr = addr;
  assign rd_bit     = rdata[plane_q];

  line_ram_2bank #(
    .DEPTH      (LINE_LEN),
    .IDX_WIDTH  (IDX_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (v2),
    .wbank (~disp),
    .widx  (i2),
    .wdata (fb.fb_data),
    .rbank (disp),
    .ridx  (rd_index),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fb_row_prefetch.sv
// Directed bench for fb_row_prefetch with a one-cycle framebuffer model
// returning (addr & 0xFF).
module tb_fb_row_prefetch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       row_req = 1'b0;
  logic [2:0] row_sel = '0;
  logic       swap = 1'b0;
  logic [8:0] rd_index = '0;
  logic [2:0] plane = '0;
  logic       row_ready;
  logic       busy;
  logic       rd_bit;
  logic       overrun;
  int         checks = 0;
  int         errors = 0;
  int         ovr;

  fb_row_prefetch_if fb ();

  fb_row_prefetch dut (
    .clk       (clk),
    .reset     (reset),
    .row_req   (row_req),
    .row_sel   (row_sel),
    .fb        (fb),
    .row_ready (row_ready),
    .busy      (busy),
    .swap      (swap),
    .rd_index  (rd_index),
    .plane     (plane),
    .rd_bit    (rd_bit),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fb.fb_data <= fb.fb_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int base, input int idx,
                                   input int pl);
    logic [7:0] d;
    d = 8'((base + idx) & 255);
    return d[pl];
  endfunction

  // Pipelined reads: set index/plane, compare rd_bit one edge later.
  task automatic sweep(input int base, input int n, input int stride,
                       input string tag);
    int bad = 0;
    int pidx = 0;
    int ppl = 0;
    for (int s = 0; s <= n; s++) begin
      @(negedge clk);
      if (s > 0 && rd_bit !== exp_bit(base, pidx, ppl)) bad++;
      if (s < n) begin
        pidx = ((s / 8) * stride) % 416;
        ppl = s % 8;
        rd_index = 9'(pidx);
        plane = 3'(ppl);
      end
    end
    chk(tag, bad, 0);
  endtask

  // Follows a fetch from the request edge up to row_ready.
  task automatic watch(input int base, input int disp, input int swap_at,
                       input int req_at, output int n_ovr);
    int addr_bad = 0;
    int busy_bad = 0;
    int rd_bad = 0;
    int rdy_k = -1;
    int pidx = 0;
    int ppl = 0;
    n_ovr = 0;
    for (int k = 0; k <= 417; k++) begin
      @(negedge clk);
      if (fb.fb_addr !== 12'(base + (k < 415 ? k : 415))) addr_bad++;
      if (busy !== (k < 417)) busy_bad++;
      if (row_ready === 1'b1 && rdy_k < 0) rdy_k = k;
      if (overrun === 1'b1) n_ovr++;
      swap = (swap_at > 0 && k == swap_at);
      row_req = (req_at > 0 && k == req_at);
      if (row_req) row_sel = 3'd5;
      if (disp >= 0) begin
        if (k > 0 && rd_bit !== exp_bit(disp, pidx, ppl)) rd_bad++;
        pidx = (k * 37) % 416;
        ppl = k % 8;
        rd_index = 9'(pidx);
        plane = 3'(ppl);
      end
    end
    chk("addr_seq", addr_bad, 0);
    chk("busy_seq", busy_bad, 0);
    chk("ready_edge", rdy_k, 417);
    if (disp >= 0) chk("rd_during_fetch", rd_bad, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", fb.fb_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", row_ready, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_rdbit", rd_bit, 0);
    reset = 1'b1;
    @(negedge clk);

    row_sel = 3'd2;
    row_req = 1'b1;
    watch(832, -1, 0, 0, ovr);
    chk("r2_ovr", ovr, 0);

    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    chk("swap_ready", row_ready, 0);
    chk("swap_ovr", overrun, 0);
    chk("swap_busy", busy, 0);
    sweep(832, 3328, 1, "sweep_r2");

    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
    chk("idle_swap_ovr", overrun, 1);
    chk("idle_swap_ready", row_ready, 0);
    @(negedge clk);
    chk("idle_swap_ovr_end", overrun, 0);
    sweep(832, 64, 13, "sweep_idle_swap");

    row_sel = 3'd1;
    row_req = 1'b1;
    watch(416, 832, 60, 100, ovr);
    chk("r1_ovr", ovr, 2);

    row_sel = 3'd3;
    row_req = 1'b1;
    swap = 1'b1;
    watch(1248, 416, 0, 0, ovr);
    chk("r3_ovr", ovr, 0);

    row_sel = 3'd6;
    row_req = 1'b1;
    @(negedge clk);
    row_req = 1'b0;
    chk("done_req_ovr", overrun, 1);
    chk("done_req_ready", row_ready, 1);
    chk("done_req_addr", fb.fb_addr, 1663);
    chk("done_req_busy", busy, 0);

    row_sel = 3'd4;
    row_req = 1'b1;
    swap = 1'b1;
    @(negedge clk);
    row_req = 1'b0;
    swap = 1'b0;
    chk("r4_start", fb.fb_addr, 1664);
    repeat (50) @(negedge clk);
    chk("r4_mid_addr", fb.fb_addr, 1714);
    chk("r4_mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_addr", fb.fb_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", row_ready, 0);
    chk("abort_ovr", overrun, 0);
    chk("abort_rdbit", rd_bit, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    row_sel = 3'd0;
    row_req = 1'b1;
    watch(0, -1, 0, 0, ovr);
    chk("r0_ovr", ovr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
